// File: rtl/noc_endpoint_ni.sv
// noc_endpoint_ni: credit-flow-controlled network interface on a router local port
module noc_endpoint_ni #(
  parameter int XCOORD     = 0,
  parameter int YCOORD     = 0,
  parameter int TX_CREDITS = 4,
  parameter int RX_DEPTH   = 4,
  parameter bit CHECK_DEST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [3:0]  tx_dest_x,
  input  logic [3:0]  tx_dest_y,
  input  logic [7:0]  tx_payload,
  output logic [15:0] data_o,
  output logic        valid_o,
  input  logic        credit_i,
  input  logic [15:0] data_i,
  input  logic        valid_i,
  output logic        credit_o,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [7:0]  rx_payload,
  output logic        err_credit,
  output logic        err_rx_ovf,
  output logic [7:0]  misroute_cnt
);
  localparam int CW = $clog2(TX_CREDITS + 1);
  localparam int AW = RX_DEPTH > 1 ? $clog2(RX_DEPTH) : 1;
  localparam int NW = $clog2(RX_DEPTH + 1);
  localparam logic [7:0] HOME = {4'(XCOORD), 4'(YCOORD)};
  localparam logic [CW-1:0] CMAX = CW'(TX_CREDITS);
  localparam logic [AW-1:0] ALAST = AW'(RX_DEPTH - 1);
  logic [CW-1:0] cred_q, cred_d;
  logic [15:0] data_q, data_d;
  logic valid_q, err_c_q, err_c_d, err_o_q, err_o_d, co_q, co_d;
  logic [7:0] mis_q, mis_d;
  logic [2:0] pend_q, pend_d;
  logic [3:0] sum;
  logic [7:0] mem [RX_DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic accept, dest_ok, pop, mis, full, wr;
  assign tx_ready     = cred_q != '0;
  assign rx_valid     = cnt_q != '0;
  assign rx_payload   = mem[rd_q];
  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign credit_o     = co_q;
  assign err_credit   = err_c_q;
  assign err_rx_ovf   = err_o_q;
  assign misroute_cnt = mis_q;
  always_comb begin
    accept  = tx_valid & tx_ready;
    data_d  = accept ? {tx_payload, tx_dest_x, tx_dest_y} : data_q;
    cred_d  = (accept & ~credit_i) ? cred_q - CW'(1)
            : (credit_i & ~accept & cred_q != CMAX) ? cred_q + CW'(1) : cred_q;
    err_c_d = err_c_q | (credit_i & ~accept & cred_q == CMAX);
    dest_ok = !CHECK_DEST || data_i[7:0] == HOME;
    pop     = rx_valid & rx_ready;
    mis     = valid_i & ~dest_ok;
    full    = cnt_q == NW'(RX_DEPTH);
    wr      = valid_i & dest_ok & (~full | pop);
    err_o_d = err_o_q | (valid_i & dest_ok & full & ~pop);
    cnt_d   = cnt_q + NW'(wr) - NW'(pop);
    rd_d    = pop ? (rd_q == ALAST ? '0 : rd_q + AW'(1)) : rd_q;
    wr_d    = wr ? (wr_q == ALAST ? '0 : wr_q + AW'(1)) : wr_q;
    mis_d   = (mis && mis_q != 8'hFF) ? mis_q + 8'd1 : mis_q;
    // credit events that cannot issue this cycle wait in pend_q
    sum     = {1'b0, pend_q} + 4'(pop) + 4'(mis);
    co_d    = sum != 4'd0;
    pend_d  = 3'(sum - 4'(co_d));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cred_q  <= CMAX;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_c_q <= 1'b0;
      err_o_q <= 1'b0;
      mis_q   <= '0;
      pend_q  <= '0;
      co_q    <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      cred_q  <= cred_d;
      data_q  <= data_d;
      valid_q <= accept;
      err_c_q <= err_c_d;
      err_o_q <= err_o_d;
      mis_q   <= mis_d;
      pend_q  <= pend_d;
      co_q    <= co_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wr_q] <= data_i[15:8];
  end
endmodule

// File: tb/tb_noc_endpoint_ni.sv
// tb_noc_endpoint_ni: directed checks of TX credits, RX FIFO, credit return and errors
module tb_noc_endpoint_ni;
  logic clk = 1'b0, rst, tx_valid, tx_ready, valid_o, credit_i, valid_i, credit_o;
  logic rx_valid, rx_ready, err_credit, err_rx_ovf;
  logic [3:0] tx_dest_x, tx_dest_y;
  logic [7:0] tx_payload, rx_payload, misroute_cnt;
  logic [15:0] data_o, data_i;
  int n_chk = 0, n_pass = 0;
  noc_endpoint_ni #(.XCOORD(1), .YCOORD(2), .TX_CREDITS(4), .RX_DEPTH(4), .CHECK_DEST(1)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dest_x(tx_dest_x),
    .tx_dest_y(tx_dest_y), .tx_payload(tx_payload), .data_o(data_o), .valid_o(valid_o),
    .credit_i(credit_i), .data_i(data_i), .valid_i(valid_i), .credit_o(credit_o),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_payload(rx_payload), .err_credit(err_credit),
    .err_rx_ovf(err_rx_ovf), .misroute_cnt(misroute_cnt)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic push(input logic [7:0] p);
    valid_i = 1'b1;
    data_i = {p, 8'h12};
    step;
    valid_i = 1'b0;
    chk("push_rx_valid", rx_valid, 1);
  endtask
  initial begin
    rst = 1'b1; tx_valid = 0; tx_dest_x = 0; tx_dest_y = 0; tx_payload = 0;
    credit_i = 0; data_i = 0; valid_i = 0; rx_ready = 0;
    step; step;
    rst = 1'b0;
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_valid_o", valid_o, 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_credit_o", credit_o, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_err_credit", err_credit, 0);
    chk("rst_err_rx_ovf", err_rx_ovf, 0);
    chk("rst_misroute", misroute_cnt, 0);
    tx_dest_x = 4'h5; tx_dest_y = 4'h6;
    for (int i = 0; i < 6; i++) begin
      tx_valid = 1'b1;
      tx_payload = 8'(i + 1);
      step;
      chk("t1_valid_o", valid_o, 16'(i < 4));
      if (i < 4) chk("t1_data_o", data_o, {8'(i + 1), 8'h56});
      chk("t1_tx_ready", tx_ready, 16'(i < 3));
    end
    tx_valid = 1'b0;
    credit_i = 1'b1;
    step;
    credit_i = 1'b0;
    chk("t2_ready_after_credit", tx_ready, 1);
    chk("t2_idle_valid_o", valid_o, 0);
    tx_valid = 1'b1; credit_i = 1'b1; tx_payload = 8'h77;
    step;
    tx_valid = 1'b0; credit_i = 1'b0;
    chk("t2_valid_o", valid_o, 1);
    chk("t2_ready_kept", tx_ready, 1);
    tx_valid = 1'b1; tx_dest_x = 4'h2; tx_dest_y = 4'h3; tx_payload = 8'hA5;
    step;
    tx_valid = 1'b0;
    chk("t3_data_o", data_o, 16'hA523);
    chk("t3_valid_o", valid_o, 1);
    chk("t3_ready_empty", tx_ready, 0);
    step;
    chk("t3_valid_one_cycle", valid_o, 0);
    credit_i = 1'b1;
    repeat (4) step;
    chk("cr_full_no_err", err_credit, 0);
    chk("cr_full_ready", tx_ready, 1);
    step;
    credit_i = 1'b0;
    chk("cr_excess_err", err_credit, 1);
    step;
    chk("cr_err_sticky", err_credit, 1);
    for (int i = 0; i < 4; i++) begin
      push(8'(8'h30 + i));
      chk("t4_fill_no_credit", credit_o, 0);
    end
    for (int i = 0; i < 4; i++) begin
      chk("t4_payload", rx_payload, 16'(8'h30 + i));
      rx_ready = 1'b1;
      step;
      chk("t4_credit_o", credit_o, 1);
    end
    rx_ready = 1'b0;
    chk("t4_empty", rx_valid, 0);
    step;
    chk("t4_credit_done", credit_o, 0);
    push(8'h41);
    push(8'h42);
    valid_i = 1'b1; data_i = 16'h9977; rx_ready = 1'b1;
    step;
    valid_i = 1'b0; rx_ready = 1'b0;
    chk("t5_misroute_cnt", misroute_cnt, 1);
    chk("t5_credit_1", credit_o, 1);
    chk("t5_rx_valid", rx_valid, 1);
    chk("t5_head", rx_payload, 16'h42);
    step;
    chk("t5_credit_2", credit_o, 1);
    step;
    chk("t5_credit_end", credit_o, 0);
    rx_ready = 1'b1;
    step;
    rx_ready = 1'b0;
    chk("t5_one_left", rx_valid, 0);
    chk("t5_pop_credit", credit_o, 1);
    step;
    chk("t5_pop_credit_end", credit_o, 0);
    for (int i = 0; i < 4; i++) push(8'(8'h50 + i));
    valid_i = 1'b1; data_i = 16'h5412; rx_ready = 1'b1;
    step;
    rx_ready = 1'b0; data_i = 16'h5512;
    chk("t6_full_pop_no_err", err_rx_ovf, 0);
    chk("t6_full_pop_credit", credit_o, 1);
    chk("t6_full_pop_head", rx_payload, 16'h51);
    step;
    valid_i = 1'b0;
    chk("t6_ovf_err", err_rx_ovf, 1);
    chk("t6_ovf_no_credit", credit_o, 0);
    chk("t6_ovf_head", rx_payload, 16'h51);
    step;
    chk("t6_ovf_sticky", err_rx_ovf, 1);
    rst = 1'b1;
    step;
    chk("t6_rst_tx_ready", tx_ready, 1);
    chk("t6_rst_valid_o", valid_o, 0);
    chk("t6_rst_data_o", data_o, 0);
    chk("t6_rst_rx_valid", rx_valid, 0);
    chk("t6_rst_credit_o", credit_o, 0);
    chk("t6_rst_err_credit", err_credit, 0);
    chk("t6_rst_err_rx_ovf", err_rx_ovf, 0);
    chk("t6_rst_misroute", misroute_cnt, 0);
    rst = 1'b0;
    step;
    chk("t6_post_rst_credit", credit_o, 0);
    chk("t6_post_rst_rx_valid", rx_valid, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
